// File: rtl/mrd_pkg.sv
// Shared types and constants for the mrd_rdx* butterflies and their output serializer.
package mrd_pkg;
   localparam int wData          = 18;
   localparam int nLane          = 5;
   localparam int wExp           = 4;
   localparam int MRD_MAX_LANE   = 5;
   localparam int MRD_MARGIN_MAX = 3;

   typedef struct packed {
      logic signed [wData-1:0] re;
      logic signed [wData-1:0] im;
   } cplx_t;

   typedef struct packed {
      cplx_t [0:MRD_MAX_LANE-1] lane;
      logic [2:0]               radix;
      logic [wExp-1:0]          exp;
      logic [1:0]               margin;
   } frame_t;

   // Out-of-range radix requests are clamped to the nearest supported butterfly.
   function automatic logic [2:0] radix_eff(input logic [2:0] r);
      if (r < 3'd2)      return 3'd2;
      else if (r > 3'd5) return 3'd5;
      else               return r;
   endfunction
endpackage

// File: rtl/mrd_sign_margin.sv
// Redundant sign-bit count of one sample, saturated at MRD_MARGIN_MAX.
module mrd_sign_margin
   import mrd_pkg::*;
(
   input  logic [wData-1:0] smp,
   output logic [1:0]       margin
);
   logic run;

   always_comb begin
      margin = '0;
      run    = 1'b1;
      for (int b = wData-2; b >= 0; b--) begin
         run = run & (smp[b] == smp[wData-1]);
         if (run && (margin != 2'(MRD_MARGIN_MAX))) margin = margin + 2'd1;
      end
   end
endmodule

// File: rtl/mrd_rdx_out_ser.sv
// Two-frame buffer that serializes butterfly output lanes and reports frame headroom.
// MRD_OUT_SER_DROP_CHK_EN enables the sticky err_drop flag for frames offered while full.
module mrd_rdx_out_ser
   import mrd_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_val,
   output logic                         in_rdy,
   input  logic [0:nLane-1][wData-1:0]  din_real,
   input  logic [0:nLane-1][wData-1:0]  din_imag,
   input  logic [2:0]                   radix,
   input  logic [wExp-1:0]              exp_in,
   output logic                         out_val,
   input  logic                         out_rdy,
   output logic [wData-1:0]             dout_real,
   output logic [wData-1:0]             dout_imag,
   output logic [2:0]                   out_idx,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [wExp-1:0]              out_exp,
   output logic [1:0]                   margin_out,
   output logic                         err_drop
);
   typedef enum logic {IDLE, SEND} state_t;

   frame_t          mem_q [0:1];
   frame_t          new_frame, src_frame;
   state_t          state_q, state_d;
   logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]      count_q, count_d;
   logic            in_rdy_q, in_rdy_d;
   logic            out_val_q, out_val_d;
   logic [wData-1:0] dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;
   logic [2:0]      idx_q, idx_d;
   logic            sop_q, sop_d, eop_q, eop_d;
   logic [wExp-1:0] exp_q, exp_d;
   logic [1:0]      margin_q, margin_d;
   logic            push, pop, ld_en;
   logic [2:0]      ld_idx, rdx_eff;
   logic [1:0]      mg_re [nLane];
   logic [1:0]      mg_im [nLane];
   logic [1:0]      frame_mg;

   assign rdx_eff = radix_eff(radix);

   for (genvar l = 0; l < nLane; l++) begin : g_mg
      mrd_sign_margin u_mg_re (.smp(din_real[l]), .margin(mg_re[l]));
      mrd_sign_margin u_mg_im (.smp(din_imag[l]), .margin(mg_im[l]));
   end

   always_comb begin
      frame_mg = 2'(MRD_MARGIN_MAX);
      for (int l = 0; l < nLane; l++) begin
         if (3'(l) < rdx_eff) begin
            if (mg_re[l] < frame_mg) frame_mg = mg_re[l];
            if (mg_im[l] < frame_mg) frame_mg = mg_im[l];
         end
      end
   end

   always_comb begin
      new_frame = '0;
      for (int l = 0; l < nLane; l++) begin
         new_frame.lane[l].re = din_real[l];
         new_frame.lane[l].im = din_imag[l];
      end
      new_frame.radix  = rdx_eff;
      new_frame.exp    = exp_in;
      new_frame.margin = frame_mg;
   end

   assign push     = in_val & in_rdy_q;
   assign pop      = (state_q == SEND) & out_rdy & eop_q;
   assign count_d  = count_q + {1'b0, push} - {1'b0, pop};
   assign wr_ptr_d = wr_ptr_q ^ push;
   assign rd_ptr_d = rd_ptr_q ^ pop;
   assign in_rdy_d = (count_d != 2'd2);

   // The entry being loaded may be written this same cycle; bypass it from the input.
   assign src_frame = (push && (wr_ptr_q == rd_ptr_d)) ? new_frame : mem_q[rd_ptr_d];

   always_comb begin
      state_d     = state_q;
      ld_en       = 1'b0;
      ld_idx      = idx_q + 3'd1;
      dout_real_d = dout_real_q;
      dout_imag_d = dout_imag_q;
      idx_d       = idx_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      exp_d       = exp_q;
      margin_d    = margin_q;
      case (state_q)
         IDLE: if ((count_q != 2'd0) || push) begin
            ld_en   = 1'b1;
            ld_idx  = 3'd0;
            state_d = SEND;
         end
         SEND: if (out_rdy) begin
            if (!eop_q) ld_en = 1'b1;
            else if (count_d != 2'd0) begin
               ld_en  = 1'b1;
               ld_idx = 3'd0;
            end else state_d = IDLE;
         end
      endcase
      out_val_d = (state_d == SEND);
      if (ld_en) begin
         dout_real_d = src_frame.lane[ld_idx].re;
         dout_imag_d = src_frame.lane[ld_idx].im;
         idx_d       = ld_idx;
         sop_d       = (ld_idx == 3'd0);
         eop_d       = (ld_idx == src_frame.radix - 3'd1);
         exp_d       = src_frame.exp;
         margin_d    = src_frame.margin;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         in_rdy_q    <= 1'b1;
         out_val_q   <= 1'b0;
         dout_real_q <= '0;
         dout_imag_q <= '0;
         idx_q       <= '0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         exp_q       <= '0;
         margin_q    <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_rdy_q    <= in_rdy_d;
         out_val_q   <= out_val_d;
         dout_real_q <= dout_real_d;
         dout_imag_q <= dout_imag_d;
         idx_q       <= idx_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         exp_q       <= exp_d;
         margin_q    <= margin_d;
         if (push) mem_q[wr_ptr_q] <= new_frame;
      end
   end

`ifdef MRD_OUT_SER_DROP_CHK_EN
   logic err_drop_q, err_drop_d;
   assign err_drop_d = err_drop_q | (in_val & ~in_rdy_q);
   always_ff @(posedge clk) begin
      if (!rst_n) err_drop_q <= 1'b0;
      else        err_drop_q <= err_drop_d;
   end
   assign err_drop = err_drop_q;
`else
   assign err_drop = 1'b0;
`endif

   assign in_rdy     = in_rdy_q;
   assign out_val    = out_val_q;
   assign dout_real  = dout_real_q;
   assign dout_imag  = dout_imag_q;
   assign out_idx    = idx_q;
   assign out_sop    = sop_q;
   assign out_eop    = eop_q;
   assign out_exp    = exp_q;
   assign margin_out = margin_q;
endmodule
